// File: rtl/key_pkg.sv
// Shared constants and helpers for the keypad event path: key count, code width,
// priority pick of the lowest pressed key and its one-hot mask.
package key_pkg;

  localparam int NKEYS = 16;
  localparam int KEY_W = 4;

  function automatic logic [KEY_W-1:0] lowest_idx(input logic [NKEYS-1:0] v);
    lowest_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[KEY_W-1:0];
    end
  endfunction

  function automatic logic [NKEYS-1:0] onehot(input logic [KEY_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Show-ahead FIFO: rd_data always presents the head entry (zero when empty).
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module key_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = KEY_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key levels into a queue of press codes, lowest index first.
// Optional auto-repeat of a single held key is enabled with KEY_REPEAT_EN.
module key_event_queue
  import key_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE  = 24'd1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NKEYS-1:0]             btn,
  input  logic                         key_ready,
  input  logic                         ovf_clr,
  output logic                         key_valid,
  output logic [KEY_W-1:0]             key_code,
  output logic [$clog2(FIFO_DEPTH):0]  key_count,
  output logic                         overflow,
  output logic                         any_down
);

  // Handshake: a code is consumed on every cycle where key_valid and key_ready
  // are both high; key_ready alone has no effect, and key_code holds until consumed.
  logic [NKEYS-1:0] s1, s2, prev, pending;
  logic [NKEYS-1:0] rise, rep, cand;
  logic [KEY_W-1:0] push_idx;
  logic             pop, push, full, empty, ovf_set;

  assign rise     = s2 & ~prev;
  assign cand     = pending | rise | rep;
  assign pop      = key_valid & key_ready;
  assign push     = (cand != '0) && (!full || pop);
  assign push_idx = lowest_idx(cand);
  assign ovf_set  = |(rise & pending);
  assign any_down = |s2;
  assign key_valid = ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
      pending <= push ? (cand & ~onehot(push_idx)) : cand;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef KEY_REPEAT_EN
  logic [23:0] rep_cnt;
  logic        held_one, rep_fire;

  assign held_one = (s2 != '0) && ((s2 & (s2 - 16'd1)) == '0);
  assign rep_fire = held_one && (s2 == prev) && (rep_cnt == REPEAT_DELAY - 24'd1);
  assign rep      = rep_fire ? s2 : '0;

  // After the first repeat the counter restarts so the next one lands REPEAT_RATE later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rep_cnt <= '0;
    else if (!held_one || s2 != prev) rep_cnt <= '0;
    else if (rep_fire)               rep_cnt <= REPEAT_DELAY - REPEAT_RATE;
    else                             rep_cnt <= rep_cnt + 24'd1;
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rep = '0;
`endif

  key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(KEY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_idx),
    .pop     (pop),
    .rd_data (key_code),
    .full    (full),
    .empty   (empty),
    .count   (key_count)
  );

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: vector table for single/simultaneous presses,
// hand sequences for full FIFO, lost events, async reset and (KEY_REPEAT_EN) auto-repeat.
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] btn;
  logic        key_ready;
  logic        ovf_clr;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  key_count;
  logic        overflow;
  logic        any_down;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

`ifdef KEY_REPEAT_EN
  key_event_queue #(.FIFO_DEPTH(8), .REPEAT_DELAY(24'd20), .REPEAT_RATE(24'd5)) dut (
`else
  key_event_queue #(.FIFO_DEPTH(8)) dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .key_ready (key_ready),
    .ovf_clr   (ovf_clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_count (key_count),
    .overflow  (overflow),
    .any_down  (any_down)
  );

  typedef struct {
    logic [15:0] btn;
    logic        rdy;
    logic        clr;
    logic        v;
    logic [3:0]  code;
    logic [3:0]  cnt;
    logic        ovf;
    logic        any;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input int k);
    btn = 16'(1 << k);
    repeat (3) step();
    btn = '0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; btn = '0; key_ready = 1'b0; ovf_clr = 1'b0;
    vecs[0]  = '{16'h0020, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{16'h0020, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[2]  = '{16'h0020, 1'b0, 1'b0, 1'b1, 4'd5, 4'd1, 1'b0, 1'b1};
    vecs[3]  = '{16'h0020, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[4]  = '{16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[5]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{16'h0208, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{16'h0208, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[8]  = '{16'h0208, 1'b1, 1'b0, 1'b1, 4'd3, 4'd1, 1'b0, 1'b1};
    vecs[9]  = '{16'h0208, 1'b1, 1'b0, 1'b1, 4'd9, 4'd1, 1'b0, 1'b1};
    vecs[10] = '{16'h0208, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[11] = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[12] = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_count", key_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_any", any_down, 0);
    rst = 1'b0;
    step();

    // Single press then simultaneous press, one vector per clock edge.
    for (int i = 0; i < 13; i++) begin
      btn = vecs[i].btn; key_ready = vecs[i].rdy; ovf_clr = vecs[i].clr;
      step();
      check($sformatf("vec%0d_valid", i), key_valid, vecs[i].v);
      check($sformatf("vec%0d_code", i), key_code, vecs[i].code);
      check($sformatf("vec%0d_count", i), key_count, vecs[i].cnt);
      check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
      check($sformatf("vec%0d_any", i), any_down, vecs[i].any);
    end
    ovf_clr = 1'b0;

    // Fill the FIFO with 0..7; key 8 must wait in pending.
    key_ready = 1'b0;
    for (int k = 0; k <= 8; k++) press(k);
    check("full_count", key_count, 8);
    check("full_head", key_code, 0);
    check("full_ovf", overflow, 0);

    // Re-press of key 8 while still pending is lost.
    press(8);
    check("lost_ovf_set", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("lost_ovf_clr", overflow, 0);

    // One pop lets pending key 8 in; count stays at 8.
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("pop_full_count", key_count, 8);
    check("pop_full_head", key_code, 1);

    for (int k = 1; k <= 8; k++) exp_q.push_back(4'(k));
    key_ready = 1'b1;
    for (int c = 0; c < 20 && key_valid; c++) begin
      if (exp_q.size() == 0) check("drain_extra", key_code, 99);
      else check($sformatf("drain_code%0d", c), key_code, exp_q.pop_front());
      step();
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_count", key_count, 0);
    check("drain_valid", key_valid, 0);

    // Async reset with three codes queued.
    key_ready = 1'b0;
    press(1); press(2); press(3);
    check("pre_rst_count", key_count, 3);
    #2 rst = 1'b1;
    #1;
    check("async_valid", key_valid, 0);
    check("async_count", key_count, 0);
    check("async_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_valid", key_valid, 0);
    press(4);
    check("post_rst_count", key_count, 1);
    check("post_rst_code", key_code, 4);
    key_ready = 1'b1;
    step();
    check("post_rst_empty", key_valid, 0);

`ifdef KEY_REPEAT_EN
    begin
      int hits;
      hits = 0;
      key_ready = 1'b1;
      btn = 16'h1000;
      for (int e = 1; e <= 34; e++) begin
        step();
        if (key_valid) begin
          hits++;
          check($sformatf("rep_code_e%0d", e), key_code, 12);
          check($sformatf("rep_time_e%0d", e),
                int'(e == 3 || e == 23 || e == 28 || e == 33), 1);
        end
      end
      check("rep_hits", hits, 4);
      hits = 0;
      btn = 16'h1002;
      for (int e = 1; e <= 40; e++) begin
        step();
        if (key_valid) begin
          hits++;
          check("rep_stop_code", key_code, 1);
        end
      end
      check("rep_stop_hits", hits, 1);
      btn = '0;
      repeat (4) step();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
